// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: forwarding selects, FSM states
// and the x0-aware register match helper.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_LD_STALL,
    HZ_FLUSH
  } hazard_state_t;

  // x0 is hard-wired zero, so it never produces a hazard or a forward.
  function automatic logic reg_hit(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_match.sv
// Per-operand comparator: EX forwarding select for the next cycle and the
// same-cycle WB bypass for the register-file read in ID.
module hazard_fwd_match
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic       ex_is_load,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output fwd_sel_t   sel,
  output logic       byp
);

  // Producers are named by where they will be once this instruction reaches EX.
  always_comb begin
    sel = FWD_RF;
    if (ex_reg_write && !ex_is_load && reg_hit(ex_rd, rs)) begin
      sel = FWD_MEM;
    end else if (mem_reg_write && reg_hit(mem_rd, rs)) begin
      sel = FWD_WB;
    end
  end

  assign byp = wb_reg_write & reg_hit(wb_rd, rs);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stall, redirect flush, forwarding selects and
// stall/flush performance counters for the 5-stage core.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             id_valid_mask,
  output logic             id_byp_a,
  output logic             id_byp_b,
  output logic [1:0]       fwd_a_ex,
  output logic [1:0]       fwd_b_ex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  hazard_state_t   state;
  logic [FC_W-1:0] fcnt;
  logic            mask_q;
  fwd_sel_t        fwd_a_q, fwd_b_q;
  fwd_sel_t        sel_a, sel_b;
  logic            lu, stall_ev;

  hazard_fwd_match u_match_a (
    .rs            (id_rs1),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_is_load    (ex_is_load),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (sel_a),
    .byp           (id_byp_a)
  );

  hazard_fwd_match u_match_b (
    .rs            (id_rs2),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_is_load    (ex_is_load),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (sel_b),
    .byp           (id_byp_b)
  );

  assign lu = id_valid & mask_q & ex_is_load & ex_reg_write
            & ((id_rs1_used & reg_hit(ex_rd, id_rs1)) | (id_rs2_used & reg_hit(ex_rd, id_rs2)));

  // A redirect squashes the ID instruction, so it overrides any load-use stall.
  assign stall_ev  = lu & ~ex_redirect;
  assign stall_if  = ~reset & stall_ev;
  assign stall_id  = ~reset & stall_ev;
  assign bubble_ex = ~reset & (stall_ev | ex_redirect);
  assign flush_id  = ~reset & ex_redirect;

  assign id_valid_mask = mask_q;
  assign fwd_a_ex      = fwd_a_q;
  assign fwd_b_ex      = fwd_b_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HZ_RUN;
      fcnt      <= '0;
      mask_q    <= 1'b1;
      fwd_a_q   <= FWD_RF;
      fwd_b_q   <= FWD_RF;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (ex_redirect) begin
        state     <= HZ_FLUSH;
        fcnt      <= FC_W'(FLUSH_CYCLES - 1);
        mask_q    <= 1'b0;
        flush_cnt <= flush_cnt + CNT_W'(1);
      end else begin
        unique case (state)
          HZ_RUN, HZ_LD_STALL: begin
            if (lu) begin
              state     <= HZ_LD_STALL;
              stall_cnt <= stall_cnt + CNT_W'(1);
            end else begin
              state <= HZ_RUN;
            end
          end
          HZ_FLUSH: begin
            if (fcnt == '0) begin
              state  <= HZ_RUN;
              mask_q <= 1'b1;
            end else begin
              fcnt <= fcnt - FC_W'(1);
            end
          end
          default: begin
            state  <= HZ_RUN;
            mask_q <= 1'b1;
          end
        endcase
      end

      if (!stall_ev) begin
        fwd_a_q <= ex_redirect ? FWD_RF : sel_a;
        fwd_b_q <= ex_redirect ? FWD_RF : sel_b;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scenarios plus a randomized run against a cycle-level behavioural
// model of the hazard sequencer.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int unsigned FC = 2;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid, id_rs1_used, id_rs2_used;
  logic [4:0]    id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic          ex_reg_write, ex_is_load, ex_redirect, mem_reg_write, wb_reg_write;
  logic          stall_if, stall_id, bubble_ex, flush_id, id_valid_mask, id_byp_a, id_byp_b;
  logic [1:0]    fwd_a_ex, fwd_b_ex;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: masked cycles still owed, expected EX selects and counters.
  int            m_rem;
  logic [1:0]    m_fa, m_fb;
  logic [CW-1:0] m_sc, m_fc;

  hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_id(flush_id),
    .id_valid_mask(id_valid_mask), .id_byp_a(id_byp_a), .id_byp_b(id_byp_b),
    .fwd_a_ex(fwd_a_ex), .fwd_b_ex(fwd_b_ex), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic hit(input logic [4:0] rd, input logic [4:0] rs);
    return rd != 0 && rd == rs;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_rd = 0; ex_reg_write = 0; ex_is_load = 0; ex_redirect = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
  endtask

  task automatic do_reset();
    reset = 1; idle();
    step();
    reset = 0;
  endtask

  // lw x5 in EX, add x6,x5,x1 in ID
  task automatic load_use_inputs();
    id_valid = 1; id_rs1 = 5; id_rs1_used = 1; id_rs2 = 1; id_rs2_used = 1;
    ex_rd = 5; ex_reg_write = 1; ex_is_load = 1;
  endtask

  task automatic test_reset();
    reset = 1; idle();
    step(); step();
    reset = 0; #1;
    checks++;
    if ({stall_if, stall_id, bubble_ex, flush_id, id_byp_a, id_byp_b} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000",
                         {stall_if, stall_id, bubble_ex, flush_id, id_byp_a, id_byp_b});
    end
    checks++;
    if ({id_valid_mask, fwd_a_ex, fwd_b_ex} !== {1'b1, FWD_RF, FWD_RF}) begin
      errors++; $display("FAIL reset_mask_fwd: got %b want 10000", {id_valid_mask, fwd_a_ex, fwd_b_ex});
    end
    checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    load_use_inputs(); #1;
    checks++;
    if ({stall_if, stall_id, bubble_ex, flush_id} !== 4'b1110) begin
      errors++; $display("FAIL lu_stall: got %b want 1110", {stall_if, stall_id, bubble_ex, flush_id});
    end
    step();
    ex_rd = 0; ex_reg_write = 0; ex_is_load = 0; mem_rd = 5; mem_reg_write = 1; #1;
    checks++;
    if ({stall_if, stall_id, bubble_ex, flush_id} !== 4'b0000 || stall_cnt !== 1) begin
      errors++; $display("FAIL lu_release: got %b cnt %0d want 0000 cnt 1",
                         {stall_if, stall_id, bubble_ex, flush_id}, stall_cnt);
    end
    step();
    checks++;
    if (fwd_a_ex !== FWD_WB || fwd_b_ex !== FWD_RF) begin
      errors++; $display("FAIL lu_fwd: got a=%0d b=%0d want a=1 b=0", fwd_a_ex, fwd_b_ex);
    end
    idle();
  endtask

  task automatic test_fwd_mem();
    do_reset();
    id_valid = 1; id_rs1 = 1; id_rs2 = 5; id_rs1_used = 1; id_rs2_used = 1;
    ex_rd = 5; ex_reg_write = 1; #1;
    checks++;
    if ({stall_if, stall_id, bubble_ex} !== 3'b000) begin
      errors++; $display("FAIL alu_nostall: got %b want 000", {stall_if, stall_id, bubble_ex});
    end
    step();
    checks++;
    if (fwd_a_ex !== FWD_RF || fwd_b_ex !== FWD_MEM) begin
      errors++; $display("FAIL alu_fwd: got a=%0d b=%0d want a=0 b=2", fwd_a_ex, fwd_b_ex);
    end
    id_rs1 = 5; mem_rd = 5; mem_reg_write = 1;
    step();
    checks++;
    if (fwd_a_ex !== FWD_MEM) begin
      errors++; $display("FAIL youngest_wins: got %0d want 2", fwd_a_ex);
    end
    ex_rd = 7;
    step();
    checks++;
    if (fwd_a_ex !== FWD_WB || fwd_b_ex !== FWD_WB) begin
      errors++; $display("FAIL mem_only_fwd: got a=%0d b=%0d want 1/1", fwd_a_ex, fwd_b_ex);
    end
    idle();
  endtask

  task automatic test_redirect_lu();
    do_reset();
    load_use_inputs(); ex_redirect = 1; #1;
    checks++;
    if ({stall_if, stall_id, bubble_ex, flush_id} !== 4'b0011) begin
      errors++; $display("FAIL redir_lu: got %b want 0011", {stall_if, stall_id, bubble_ex, flush_id});
    end
    for (int i = 0; i < FC; i++) begin
      step();
      ex_redirect = 0; #1;
      checks++;
      if (id_valid_mask !== 1'b0 || {stall_if, stall_id, bubble_ex} !== 3'b000) begin
        errors++; $display("FAIL flush_mask cyc%0d: mask %b stall %b want 0 000",
                           i, id_valid_mask, {stall_if, stall_id, bubble_ex});
      end
    end
    step();
    idle(); #1;
    checks++;
    if (id_valid_mask !== 1'b1 || flush_cnt !== 1 || stall_cnt !== 0) begin
      errors++; $display("FAIL flush_end: mask %b fc %0d sc %0d want 1 1 0",
                         id_valid_mask, flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_x0();
    do_reset();
    id_valid = 1; id_rs1_used = 1; id_rs2_used = 1;
    ex_reg_write = 1; ex_is_load = 1; mem_reg_write = 1; wb_reg_write = 1; #1;
    checks++;
    if ({stall_if, bubble_ex, id_byp_a, id_byp_b} !== 4'b0000) begin
      errors++; $display("FAIL x0_nohazard: got %b want 0000", {stall_if, bubble_ex, id_byp_a, id_byp_b});
    end
    ex_is_load = 0;
    step();
    checks++;
    if (fwd_a_ex !== FWD_RF || fwd_b_ex !== FWD_RF) begin
      errors++; $display("FAIL x0_fwd: got a=%0d b=%0d want 0/0", fwd_a_ex, fwd_b_ex);
    end
    wb_rd = 3; id_rs1 = 3; id_rs2 = 4; #1;
    checks++;
    if ({id_byp_a, id_byp_b} !== 2'b10) begin
      errors++; $display("FAIL wb_bypass: got %b want 10", {id_byp_a, id_byp_b});
    end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    ex_redirect = 1;
    step();
    #1;
    checks++;
    if ({bubble_ex, flush_id} !== 2'b11 || id_valid_mask !== 1'b0) begin
      errors++; $display("FAIL redir_in_flush: got %b mask %b want 11 0", {bubble_ex, flush_id}, id_valid_mask);
    end
    for (int i = 0; i < FC; i++) begin
      step();
      ex_redirect = 0; #1;
      checks++;
      if (id_valid_mask !== 1'b0) begin
        errors++; $display("FAIL restart_mask cyc%0d: got %b want 0", i, id_valid_mask);
      end
    end
    step();
    checks++;
    if (id_valid_mask !== 1'b1 || flush_cnt !== 2) begin
      errors++; $display("FAIL restart_end: mask %b fc %0d want 1 2", id_valid_mask, flush_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_use_inputs();
    step();
    reset = 1; #1;
    checks++;
    if ({stall_if, stall_id, bubble_ex, flush_id} !== 4'b0000) begin
      errors++; $display("FAIL reset_gates: got %b want 0000", {stall_if, stall_id, bubble_ex, flush_id});
    end
    step();
    reset = 0; idle(); #1;
    checks++;
    if (stall_cnt !== 0 || id_valid_mask !== 1'b1 || fwd_a_ex !== FWD_RF || stall_if !== 1'b0) begin
      errors++; $display("FAIL reset_in_stall: sc %0d mask %b fa %0d stall %b want 0 1 0 0",
                         stall_cnt, id_valid_mask, fwd_a_ex, stall_if);
    end
    ex_redirect = 1;
    step();
    ex_redirect = 0; reset = 1;
    step();
    reset = 0; #1;
    checks++;
    if (id_valid_mask !== 1'b1 || flush_cnt !== 0) begin
      errors++; $display("FAIL reset_in_flush: mask %b fc %0d want 1 0", id_valid_mask, flush_cnt);
    end
  endtask

  task automatic test_random();
    logic       masked, lu, stall, bub;
    logic [1:0] sa, sb;
    do_reset();
    m_rem = 0; m_fa = FWD_RF; m_fb = FWD_RF; m_sc = 0; m_fc = 0;
    for (int i = 0; i < 6000; i++) begin
      checks++;
      if ({id_valid_mask, fwd_a_ex, fwd_b_ex} !== {(m_rem == 0), m_fa, m_fb}) begin
        errors++; $display("FAIL rnd_regs cyc%0d: got %b want %b", i,
                           {id_valid_mask, fwd_a_ex, fwd_b_ex}, {(m_rem == 0), m_fa, m_fb});
      end
      checks++;
      if (stall_cnt !== m_sc || flush_cnt !== m_fc) begin
        errors++; $display("FAIL rnd_cnt cyc%0d: got %0d/%0d want %0d/%0d", i,
                           stall_cnt, flush_cnt, m_sc, m_fc);
      end
      reset = ($urandom_range(0, 1999) == 0);
      id_valid = ($urandom_range(0, 9) != 0);
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
      ex_rd = 5'($urandom_range(0, 7)); ex_reg_write = ($urandom_range(0, 3) != 0);
      ex_is_load = ($urandom_range(0, 9) < 7); ex_redirect = ($urandom_range(0, 19) == 0);
      mem_rd = 5'($urandom_range(0, 7)); mem_reg_write = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 7)); wb_reg_write = 1'($urandom);
      #1;
      masked = (m_rem != 0);
      lu = id_valid && !masked && ex_is_load && ex_reg_write &&
           ((id_rs1_used && hit(ex_rd, id_rs1)) || (id_rs2_used && hit(ex_rd, id_rs2)));
      stall = lu && !ex_redirect;
      bub = stall || ex_redirect;
      checks++;
      if ({stall_if, stall_id, bubble_ex, flush_id} !==
          (reset ? 4'b0000 : {stall, stall, bub, ex_redirect})) begin
        errors++; $display("FAIL rnd_ctrl cyc%0d: got %b want %b", i,
                           {stall_if, stall_id, bubble_ex, flush_id},
                           (reset ? 4'b0000 : {stall, stall, bub, ex_redirect}));
      end
      checks++;
      if ({id_byp_a, id_byp_b} !== {wb_reg_write && hit(wb_rd, id_rs1), wb_reg_write && hit(wb_rd, id_rs2)}) begin
        errors++; $display("FAIL rnd_byp cyc%0d: got %b", i, {id_byp_a, id_byp_b});
      end
      sa = (ex_reg_write && !ex_is_load && hit(ex_rd, id_rs1)) ? FWD_MEM :
           (mem_reg_write && hit(mem_rd, id_rs1)) ? FWD_WB : FWD_RF;
      sb = (ex_reg_write && !ex_is_load && hit(ex_rd, id_rs2)) ? FWD_MEM :
           (mem_reg_write && hit(mem_rd, id_rs2)) ? FWD_WB : FWD_RF;
      if (reset) begin
        m_rem = 0; m_fa = FWD_RF; m_fb = FWD_RF; m_sc = 0; m_fc = 0;
      end else begin
        if (ex_redirect) begin
          m_rem = FC; m_fc = m_fc + 1'b1;
        end else if (masked) begin
          m_rem = m_rem - 1;
        end
        if (stall) m_sc = m_sc + 1'b1;
        if (!stall) begin
          m_fa = bub ? FWD_RF : sa;
          m_fb = bub ? FWD_RF : sb;
        end
      end
      step();
    end
    reset = 0; idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_fwd_mem();
    test_redirect_lu();
    test_x0();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
